ext_dram_bridge: RTL

- Upstream feeder for the external channel of the DRAM arbiter.
- Converts an external valid/ready request channel plus response channel into the single-cycle lsu_req_t/lsu_ack_t protocol.
- Captures SRAM read data one cycle after grant and buffers responses in a small FIFO.
- Throttles back-to-back external bursts so the lower-priority core port is not starved.

---
 rtl/ext_dram_bridge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ext_dram_bridge.sv
// ext_dram_bridge: connects an external valid/ready request/response pair to
// the arbiter's single-cycle lsu request/ack channel. SRAM read data arrives
// one cycle after grant and goes into a small response FIFO. Request issue is
// limited by FIFO credit, and long external bursts are broken up so that a
// waiting core port gets a turn.

package ext_dram_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } lsu_req_t;

    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
        logic        error;
    } lsu_ack_t;

endpackage

module ext_dram_bridge
    import ext_dram_pkg::*;
#(
    parameter int RSP_DEPTH = 2,
    parameter int MAX_BURST = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ext_req_valid_i,
    output logic        ext_req_ready_o,
    input  logic [31:0] ext_req_addr_i,
    input  logic        ext_req_we_i,
    input  logic [31:0] ext_req_wdata_i,
    input  logic [3:0]  ext_req_strb_i,
    output logic        ext_rsp_valid_o,
    input  logic        ext_rsp_ready_i,
    output logic [31:0] ext_rsp_rdata_o,
    output logic        ext_rsp_we_o,
    output logic        ext_rsp_error_o,
    input  logic        core_pending_i,
    output lsu_req_t    ext_dram_req_o,
    input  lsu_ack_t    ext_dram_ack_i
);

    localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
    localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [CNT_W:0]     DEPTH_LIM = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    logic [31:0]        fifo_rdata [RSP_DEPTH];
    logic               fifo_we    [RSP_DEPTH];
    logic               fifo_error [RSP_DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               pend_vld;
    logic               pend_we;
    logic [BURST_W-1:0] burst_cnt;

    logic               credit_ok;
    logic               throttle;
    logic               issue;
    logic               push;
    logic               pop;

    // Credit is based only on registered state, so a pop in this cycle does
    // not free a slot until the next cycle.
    assign credit_ok = ({1'b0, count} + {{CNT_W{1'b0}}, pend_vld}) < DEPTH_LIM;

    assign throttle = (MAX_BURST != 0) && (burst_cnt == BURST_LIM) && core_pending_i;

    // Request toward the arbiter. Fields pass straight through, reads always
    // use full byte enables, and the whole bus is held at zero during reset.
    always_comb begin
        ext_dram_req_o = '0;
        if (rst_ni) begin
            ext_dram_req_o.req   = ext_req_valid_i & credit_ok & ~throttle;
            ext_dram_req_o.addr  = ext_req_addr_i;
            ext_dram_req_o.we    = ext_req_we_i;
            ext_dram_req_o.wdata = ext_req_wdata_i;
            ext_dram_req_o.strb  = ext_req_we_i ? ext_req_strb_i : 4'hF;
        end
    end

    assign ext_req_ready_o = ext_dram_req_o.req & ext_dram_ack_i.ack;
    assign issue           = ext_req_valid_i & ext_req_ready_o;

    assign push = pend_vld;
    assign pop  = ext_rsp_valid_o & ext_rsp_ready_i;

    assign ext_rsp_valid_o = rst_ni & (count != '0);
    assign ext_rsp_rdata_o = fifo_rdata[rd_ptr];
    assign ext_rsp_we_o    = fifo_we[rd_ptr];
    assign ext_rsp_error_o = fifo_error[rd_ptr];

    // Remember that a grant happened so its SRAM data is captured next cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_vld <= 1'b0;
            pend_we  <= 1'b0;
        end else begin
            pend_vld <= issue;
            pend_we  <= issue & ext_req_we_i;
        end
    end

    // Capture the ack data into the tail slot. Writes always return zero data.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            fifo_rdata[wr_ptr] <= pend_we ? 32'h0 : ext_dram_ack_i.rdata;
            fifo_we[wr_ptr]    <= pend_we;
            fifo_error[wr_ptr] <= ext_dram_ack_i.error;
        end
    end

    // FIFO pointers and occupancy. A push and a pop together keep the count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Count back-to-back issues. Any idle or throttled cycle resets the run.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            burst_cnt <= '0;
        end else if (!issue) begin
            burst_cnt <= '0;
        end else if (burst_cnt != BURST_LIM) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
        end
    end

endmodule
